// File: rtl/vx_csa_accum_ctrl.sv
// vx_csa_accum_ctrl: multi-beat carry-save accumulator with a start/in/out handshake.
// A job is opened with start_beats. Each accepted beat adds its unmasked lanes
// into a carry-save pair (acc_s, acc_c). One resolve cycle then adds the pair
// into out_sum, which is held until the consumer accepts it.
// Ports:
//   clk, reset                   - clock, synchronous active-high reset
//   start_valid/ready, start_beats - job request and its beat count
//   in_valid/ready, in_data, in_mask - operand beat, LANES lanes of W bits each
//   out_valid/ready, out_sum     - result handshake and the S-bit sum
//   busy                         - high whenever the controller is not idle
module vx_csa_accum_ctrl #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned W         = 8,
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned S         = W + $clog2(LANES * MAX_BEATS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start_valid,
  input  logic [$clog2(MAX_BEATS+1)-1:0]     start_beats,
  output logic                               start_ready,
  input  logic                               in_valid,
  input  logic [LANES-1:0][W-1:0]            in_data,
  input  logic [LANES-1:0]                   in_mask,
  output logic                               in_ready,
  output logic                               out_valid,
  output logic [S-1:0]                       out_sum,
  input  logic                               out_ready,
  output logic                               busy
);

  localparam int unsigned CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  state_t          state, state_d;
  logic            start_fire, beat_fire;
  logic [S-1:0]    acc_s, acc_c;
  logic [S-1:0]    tree_s, tree_c, term, nxt_s, nxt_c;
  logic [CW-1:0]   cnt, beats_clamped;

  // Requests above MAX_BEATS are clamped
  assign beats_clamped = (start_beats > CW'(MAX_BEATS)) ? CW'(MAX_BEATS) : start_beats;

  // 3:2 compressor chain folding each masked lane into the carry-save pair.
  // S is sized so the exact sum always fits, so carries shifted out are zero.
  always_comb begin
    tree_s = acc_s;
    tree_c = acc_c;
    term   = '0;
    nxt_s  = '0;
    nxt_c  = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      term   = in_mask[i] ? S'(in_data[i]) : '0;
      nxt_s  = tree_s ^ tree_c ^ term;
      nxt_c  = ((tree_s & tree_c) | (tree_s & term) | (tree_c & term)) << 1;
      tree_s = nxt_s;
      tree_c = nxt_c;
    end
  end

  // Next-state and handshake fire decode
  always_comb begin
    state_d    = state;
    start_fire = 1'b0;
    beat_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (start_valid) begin
          start_fire = 1'b1;
          state_d    = (start_beats == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          beat_fire = 1'b1;
          if (cnt == CW'(1)) state_d = RESOLVE;
        end
      end
      RESOLVE: state_d = DONE;
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; handshake flags are registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      start_ready <= 1'b1;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      start_ready <= (state_d == IDLE);
      in_ready    <= (state_d == ACCUM);
      out_valid   <= (state_d == DONE);
      busy        <= (state_d != IDLE);
    end
  end

  // Accumulator, beat counter and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_s   <= '0;
      acc_c   <= '0;
      cnt     <= '0;
      out_sum <= '0;
    end else begin
      if (start_fire) begin
        acc_s   <= '0;
        acc_c   <= '0;
        cnt     <= beats_clamped;
        out_sum <= '0;
      end
      if (beat_fire) begin
        acc_s <= tree_s;
        acc_c <= tree_c;
        cnt   <= cnt - CW'(1);
      end
      if (state == RESOLVE) out_sum <= acc_s + acc_c;
    end
  end

endmodule

// File: tb/tb_vx_csa_accum_ctrl.sv
// Directed bench for vx_csa_accum_ctrl (LANES=4, W=8, MAX_BEATS=16, S=14).
// Expected sums are queued as jobs are issued; a negedge monitor pops one per
// output handshake and compares. Latency, hold and reset behaviour are checked
// inline by the stimulus process.
module tb_vx_csa_accum_ctrl;

  logic             clk = 1'b0;
  logic             reset;
  logic             start_valid;
  logic [4:0]       start_beats;
  logic             start_ready;
  logic             in_valid;
  logic [3:0][7:0]  in_data;
  logic [3:0]       in_mask;
  logic             in_ready;
  logic             out_valid;
  logic [13:0]      out_sum;
  logic             out_ready;
  logic             busy;

  int checks = 0;
  int fails  = 0;
  int unsigned exp_q[$];

  vx_csa_accum_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_beats (start_beats),
    .start_ready (start_ready),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_mask     (in_mask),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_sum     (out_sum),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one pop per output handshake
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        check("out_sum", int'(out_sum), exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0][7:0] pk(input logic [7:0] a, b, c, d);
    logic [3:0][7:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  task automatic start_job(input logic [4:0] n);
    check("start_ready", start_ready, 1);
    start_valid = 1'b1;
    start_beats = n;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic beat(input logic [3:0][7:0] d, input logic [3:0] m);
    int n = 0;
    while (!in_ready && n < 10) begin
      tick();
      n++;
    end
    check("in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_mask  = m;
    tick();
    in_valid = 1'b0;
  endtask

  // Called right after the firing edge; counts edges from that edge to out_valid
  task automatic wait_out(input string name, input int exp_lat);
    int lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check(name, lat, exp_lat);
  endtask

  initial begin
    reset       = 1'b1;
    start_valid = 1'b0;
    start_beats = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_mask     = '0;
    out_ready   = 1'b1;
    tick();
    tick();
    check("rst_start_ready", start_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    reset = 1'b0;
    tick();

    // One beat, full mask: 1+2+3+4
    exp_q.push_back(10);
    start_job(5'd1);
    check("busy_accum", busy, 1);
    beat(pk(8'd1, 8'd2, 8'd3, 8'd4), 4'b1111);
    check("resolve_not_valid", out_valid, 0);
    wait_out("lat_1beat", 2);
    tick();

    // Sixteen beats of all-ones lanes: 16*4*255
    exp_q.push_back(16320);
    start_job(5'd16);
    for (int i = 0; i < 16; i++) beat(pk(8'hFF, 8'hFF, 8'hFF, 8'hFF), 4'b1111);
    wait_out("lat_16beat", 2);
    tick();

    // Zero-beat job: result next cycle, never accepts a beat
    exp_q.push_back(0);
    start_job(5'd0);
    check("zero_in_ready", in_ready, 0);
    wait_out("lat_zero", 1);
    tick();

    // Three beats with gaps, consumer stalls: 10 + 26 + (200+255+1)
    exp_q.push_back(492);
    start_job(5'd3);
    beat(pk(8'd1, 8'd2, 8'd3, 8'd4), 4'b1111);
    tick();
    beat(pk(8'd5, 8'd6, 8'd7, 8'd8), 4'b1111);
    tick();
    out_ready = 1'b0;
    beat(pk(8'd100, 8'd200, 8'd255, 8'd1), 4'b1110);
    wait_out("lat_gap", 2);
    start_valid = 1'b1;
    start_beats = 5'd0;
    for (int i = 0; i < 5; i++) begin
      check("hold_sum", out_sum, 492);
      check("hold_valid", out_valid, 1);
      check("hold_start_ready", start_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    // start held high through the out fire must not have been taken yet
    check("post_fire_busy", busy, 0);
    check("post_fire_start_ready", start_ready, 1);
    exp_q.push_back(0);
    tick();
    start_valid = 1'b0;
    check("late_start_valid", out_valid, 1);
    tick();

    // Beats offered while idle are ignored
    in_valid = 1'b1;
    in_data  = pk(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    in_mask  = 4'b1111;
    tick();
    tick();
    in_valid = 1'b0;
    check("idle_beat_busy", busy, 0);

    // Masked lanes: only lanes 0 and 2 count, 10+30
    exp_q.push_back(40);
    start_job(5'd1);
    beat(pk(8'd10, 8'd20, 8'd30, 8'd40), 4'b0101);
    wait_out("lat_mask", 2);
    tick();

    // Abort a four-beat job after two beats
    start_job(5'd4);
    beat(pk(8'd50, 8'd60, 8'd70, 8'd80), 4'b1111);
    beat(pk(8'd50, 8'd60, 8'd70, 8'd80), 4'b1111);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_start_ready", start_ready, 1);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_sum", out_sum, 0);
    exp_q.push_back(4);
    start_job(5'd1);
    beat(pk(8'd1, 8'd1, 8'd1, 8'd1), 4'b1111);
    wait_out("lat_after_abort", 2);
    tick();
    tick();

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/vx_csa_accum_ctrl.md
VX_CSA_ACCUM_CTRL -- requirements
Module: VX_csa_accum_ctrl

Interface
REQ-001 SHALL have parameter LANES, default 4, giving operands accepted per input beat (LANES >= 2).
REQ-002 SHALL have parameter W, default 8, giving the unsigned operand width.
REQ-003 SHALL have parameter MAX_BEATS, default 16, giving the maximum beats per job (MAX_BEATS >= 1).
REQ-004 SHALL have parameter S, default W + $clog2(LANES*MAX_BEATS), giving the result width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start_valid, input, 1, job request.
REQ-008 SHALL have port start_beats, input, $clog2(MAX_BEATS+1), the number of beats in the job.
REQ-009 SHALL have port start_ready, output, 1, job request accepted when high together with start_valid.
REQ-010 SHALL have port in_valid, input, 1, operand beat valid.
REQ-011 SHALL have port in_data, input, [LANES][W], the operand beat.
REQ-012 SHALL have port in_mask, input, LANES, per-lane enable; a masked-off lane contributes zero.
REQ-013 SHALL have port in_ready, output, 1, beat accepted when high together with in_valid.
REQ-014 SHALL have port out_valid, output, 1, result available.
REQ-015 SHALL have port out_sum, output, S, the result.
REQ-016 SHALL have port out_ready, input, 1, result consumed when high together with out_valid.
REQ-017 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ACCUM, RESOLVE and DONE.
REQ-019 In IDLE: start_ready=1, in_ready=0, out_valid=0.
REQ-020 On a start fire: carry-save registers acc_s/acc_c SHALL clear to 0 and the beat counter SHALL load min(start_beats, MAX_BEATS).
REQ-021 After a start fire: start_beats==0 -> DONE with out_sum=0; otherwise -> ACCUM.
REQ-022 In ACCUM: in_ready=1 and start_ready=0; cycles without in_valid SHALL leave state and registers unchanged.
REQ-023 On each beat fire, the masked LANES operands plus acc_s and acc_c (LANES+2 terms) SHALL reduce through a carry-save tree to a new (acc_s, acc_c) pair of width S, and the counter SHALL decrement.
REQ-024 When the fire consumes the last beat (counter==1), next state SHALL be RESOLVE.
REQ-025 In RESOLVE (exactly one cycle): out_sum register <= acc_s + acc_c (carry-propagate, modulo 2^S), next state DONE; in_ready=0.
REQ-026 In DONE: out_valid=1 and out_sum SHALL hold stable until out_ready; on an out fire, next state IDLE.
REQ-027 Latency: last beat accepted in cycle t -> out_valid=1 in cycle t+2; a zero-beat start accepted in cycle t -> out_valid=1 in cycle t+1.
REQ-028 Operands SHALL be zero-extended; out_sum SHALL equal the exact unsigned sum of all unmasked operands of the job (no overflow by sizing of S).
REQ-029 A new start SHALL NOT be accepted in the cycle of an out fire; the earliest start is the cycle after.
REQ-030 in_valid outside ACCUM and start_valid outside IDLE SHALL be ignored with no state change.

Reset
REQ-031 reset high at a clock edge SHALL force IDLE, acc_s=acc_c=0, counter=0, out_sum=0, out_valid=0, in_ready=0, busy=0, start_ready=1, overriding any simultaneous handshake.
REQ-032 Reset mid-job SHALL discard all partial state; the next job's result SHALL be independent of the aborted job.

Verification (LANES=4, W=8, MAX_BEATS=16, S=14)
REQ-033 start_beats=1; beat {1,2,3,4}, mask 4'b1111 at cycle t -> out_valid at t+2, out_sum=10.
REQ-034 start_beats=16; every lane 0xFF, all masks 1 -> out_sum=16320 (0x3FC0).
REQ-035 start_beats=0 -> in_ready never high; out_valid next cycle with out_sum=0.
REQ-036 start_beats=3 with one idle cycle between beats; out_ready low for 5 cycles -> out_sum stable and start_ready=0 throughout; IDLE after out fire.
REQ-037 Beat {10,20,30,40}, mask 4'b0101, start_beats=1 -> out_sum=40.
REQ-038 reset after 2 of 4 beats -> next cycle busy=0, start_ready=1; new 1-beat job {1,1,1,1} -> out_sum=4.
